req_gnt_checker: RTL and testbench
==================================

REQ_GNT_CHECKER -- requirements
Module: req_gnt_checker

Interface
REQ-001 Parameter N_CH, default 1: number of independent req/gnt channels, 1..32.
REQ-002 Parameter MIN_LAT, default 2: earliest legal grant cycle after trigger, >=1.
REQ-003 Parameter MAX_LAT, default 2: latest legal grant cycle after trigger, MIN_LAT<=MAX_LAT<=255.
REQ-004 Parameter CNT_W, default 16: width of the aggregate pass and fail counters.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  checker enable.
REQ-008 cStart  input  N_CH  per-channel check start (antecedent).
REQ-009 req  input  N_CH  per-channel request.
REQ-010 gnt  input  N_CH  per-channel grant.
REQ-011 pass  output  N_CH  one-cycle per-channel pass pulse.
REQ-012 fail  output  N_CH  one-cycle per-channel fail pulse.
REQ-013 fail_code  output  2*N_CH  per-channel cause, valid with fail: 01 early, 10 timeout, 11 no_req.
REQ-014 ovl  output  N_CH  one-cycle pulse: trigger ignored while channel busy.
REQ-015 pass_cnt  output  CNT_W  saturating count of pass events.
REQ-016 fail_cnt  output  CNT_W  saturating count of fail events.

Function
REQ-017 Each channel SHALL run an FSM with states IDLE and WAIT, plus a latency counter k of width clog2(MAX_LAT+1).
REQ-018 Trigger: an edge where en=1 and cStart[i]=1; the trigger edge is k=0.
REQ-019 Trigger with req[i]=0: the channel SHALL report fail with code 11 and stay IDLE.
REQ-020 Trigger with req[i]=1: the channel SHALL enter WAIT with k=0.
REQ-021 In WAIT, at each later edge, k SHALL increment first, then be evaluated in this order.
REQ-022 gnt[i]=1 and k>=MIN_LAT: pass, return to IDLE.
REQ-023 gnt[i]=1 and k<MIN_LAT: fail with code 01, return to IDLE.
REQ-024 gnt[i]=0 and k==MAX_LAT: fail with code 10, return to IDLE.
REQ-025 A trigger on the same edge a channel resolves SHALL be accepted as a new check (back-to-back).
REQ-026 A trigger in WAIT on a non-resolving edge SHALL be ignored and pulse ovl[i].
REQ-027 pass, fail, fail_code and ovl SHALL be registered and asserted for exactly the one cycle after the deciding edge; fail_code SHALL be 00 when fail is 0.
REQ-028 The gnt[i] value on the trigger edge SHALL be ignored.
REQ-029 en=0 SHALL return all channels to IDLE without reporting and SHALL block triggers; counters SHALL hold.
REQ-030 pass_cnt and fail_cnt SHALL each add the popcount of that cycle's pass or fail vector, saturating at 2^CNT_W-1.
REQ-031 With defaults, behaviour SHALL equal "cStart |-> req ##2 gnt" sampled on posedge clk.

Reset
REQ-032 reset=0 SHALL asynchronously force all channels to IDLE, set k=0, and clear pass, fail, fail_code, ovl, pass_cnt and fail_cnt to 0.
REQ-033 Reset asserted mid-check SHALL abandon the check with no report.
REQ-034 The first trigger SHALL be recognised on the first posedge after reset deasserts.

Structure
REQ-035 Shared package chk_pkg SHALL hold the state typedef (IDLE, WAIT) and the fail_code enum (NONE=00, EARLY=01, TIMEOUT=10, NO_REQ=11).
REQ-036 One sub-module req_gnt_chan SHALL implement a single channel FSM; the top SHALL instantiate N_CH copies and hold the popcount and saturating counters.

Verification
REQ-037 Defaults, req=1 with cStart at edge T, gnt=1 at edge T+2 -> pass=1 in cycle after T+2, pass_cnt=1.
REQ-038 Defaults, gnt at T+1 -> fail with code 01; separately, gnt never asserted -> fail with code 10 after T+2; fail_cnt=2.
REQ-039 cStart=1 with req=0 -> fail with code 11 in cycle after T, channel stays IDLE.
REQ-040 MIN_LAT=2, MAX_LAT=5, retrigger at T+3 before grant -> ovl pulse; grant at T+5 -> pass; retrigger on the T+5 edge accepted.
REQ-041 N_CH=4, CNT_W=3, all channels pass on the same edge twice -> pass_cnt=7 (saturated).
REQ-042 reset driven low mid-WAIT at T+1 -> no pass or fail, all outputs 0 immediately; en=0 mid-WAIT -> silent abort.

Source files
------------

// File: rtl/chk_pkg.sv
// Shared types for the request/grant latency checker.
package chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } chan_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        EARLY   = 2'b01,
        TIMEOUT = 2'b10,
        NO_REQ  = 2'b11
    } fail_code_t;

endpackage

// File: rtl/req_gnt_chan.sv
// Single-channel checker: a trigger with req open a window in which gnt must
// arrive between MIN_LAT and MAX_LAT edges later.
module req_gnt_chan
    import chk_pkg::*;
#(
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       cstart,
    input  logic       req,
    input  logic       gnt,
    output logic       pass,
    output logic       fail,
    output logic [1:0] fail_code,
    output logic       ovl
);

    localparam int KW = $clog2(MAX_LAT + 1);

    chan_state_t   state;
    logic [KW-1:0] k;
    logic [KW-1:0] kn;
    logic          hit_gnt;
    logic          hit_to;
    logic          early;
    logic          resolve;
    logic          fail_res;

    assign kn       = k + KW'(1);
    assign hit_gnt  = (state == WAIT) && gnt;
    assign hit_to   = (state == WAIT) && !gnt && (kn == KW'(MAX_LAT));
    assign early    = kn < KW'(MIN_LAT);
    assign resolve  = hit_gnt || hit_to;
    assign fail_res = hit_to || (hit_gnt && early);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= NONE;
            ovl       <= 1'b0;
        end else begin
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= NONE;
            ovl       <= 1'b0;
            if (!en) begin
                state <= IDLE;
                k     <= '0;
            end else begin
                if (state == WAIT)
                    k <= kn;
                if (resolve) begin
                    state <= IDLE;
                    k     <= '0;
                end
                if (hit_gnt && !early)
                    pass <= 1'b1;
                if (hit_gnt && early) begin
                    fail      <= 1'b1;
                    fail_code <= EARLY;
                end
                if (hit_to) begin
                    fail      <= 1'b1;
                    fail_code <= TIMEOUT;
                end
                // A resolving edge frees the channel, so a trigger there starts a new check.
                if (cstart) begin
                    if ((state == WAIT) && !resolve) begin
                        ovl <= 1'b1;
                    end else if (req) begin
                        state <= WAIT;
                        k     <= '0;
                    end else begin
                        fail <= 1'b1;
                        // The completing check's cause wins when both fail on one edge.
                        if (!fail_res)
                            fail_code <= NO_REQ;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/req_gnt_checker.sv
// N_CH independent req/gnt latency checkers with saturating aggregate
// pass/fail counters.
module req_gnt_checker
    import chk_pkg::*;
#(
    parameter int N_CH    = 1,
    parameter int MIN_LAT = 2,
    parameter int MAX_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_CH-1:0]   cStart,
    input  logic [N_CH-1:0]   req,
    input  logic [N_CH-1:0]   gnt,
    output logic [N_CH-1:0]   pass,
    output logic [N_CH-1:0]   fail,
    output logic [2*N_CH-1:0] fail_code,
    output logic [N_CH-1:0]   ovl,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int SW = CNT_W + 6;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        req_gnt_chan #(
            .MIN_LAT (MIN_LAT),
            .MAX_LAT (MAX_LAT)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .cstart    (cStart[g]),
            .req       (req[g]),
            .gnt       (gnt[g]),
            .pass      (pass[g]),
            .fail      (fail[g]),
            .fail_code (fail_code[2*g +: 2]),
            .ovl       (ovl[g])
        );
    end

    logic [SW-1:0]    pass_sum;
    logic [SW-1:0]    fail_sum;
    logic [CNT_W-1:0] pass_nxt;
    logic [CNT_W-1:0] fail_nxt;

    // Counters fold in the registered pulse vector, so they trail pass/fail by one cycle.
    assign pass_sum = SW'(pass_cnt) + SW'($countones(pass));
    assign fail_sum = SW'(fail_cnt) + SW'($countones(fail));
    assign pass_nxt = (pass_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
    assign fail_nxt = (fail_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (en) begin
            pass_cnt <= pass_nxt;
            fail_cnt <= fail_nxt;
        end
    end

endmodule

// File: tb/tb_req_gnt_checker.sv
// Two checker configurations (fixed 2-cycle latency, and a 2..5 window) driven
// in parallel and compared with a latency-timestamp reference model.
module tb_req_gnt_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] cStart, req, gnt;

    logic [3:0]  p0, f0, o0, p1, f1, o1;
    logic [7:0]  fc0, fc1;
    logic [2:0]  pc0, fcnt0;
    logic [15:0] pc1, fcnt1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    req_gnt_checker #(.N_CH(4), .MIN_LAT(2), .MAX_LAT(2), .CNT_W(3)) dut0 (
        .clk(clk), .reset(reset), .en(en), .cStart(cStart), .req(req), .gnt(gnt),
        .pass(p0), .fail(f0), .fail_code(fc0), .ovl(o0), .pass_cnt(pc0), .fail_cnt(fcnt0));

    req_gnt_checker #(.N_CH(4), .MIN_LAT(2), .MAX_LAT(5), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .en(en), .cStart(cStart), .req(req), .gnt(gnt),
        .pass(p1), .fail(f1), .fail_code(fc1), .ovl(o1), .pass_cnt(pc1), .fail_cnt(fcnt1));

    // Reference model: a busy channel remembers the cycle it was triggered.
    int         minl[2] = '{2, 2};
    int         maxl[2] = '{2, 5};
    int         cmax[2] = '{7, 65535};
    bit         busy[2][4];
    int         t0[2][4];
    int         cyc = 0;
    logic [3:0] ep[2], ef[2], eo[2];
    logic [7:0] ec[2];
    int         epc[2], efc[2];

    task automatic model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 4; c++) busy[m][c] = 1'b0;
            ep[m] = '0; ef[m] = '0; eo[m] = '0; ec[m] = '0;
            epc[m] = 0; efc[m] = 0;
        end
    endtask

    task automatic model_edge();
        int lat;
        logic [1:0] code;
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (en) begin
                epc[m] = (epc[m] + $countones(ep[m]) > cmax[m]) ? cmax[m] : epc[m] + $countones(ep[m]);
                efc[m] = (efc[m] + $countones(ef[m]) > cmax[m]) ? cmax[m] : efc[m] + $countones(ef[m]);
            end
            ep[m] = '0; ef[m] = '0; eo[m] = '0; ec[m] = '0;
            for (int c = 0; c < 4; c++) begin
                if (!en) begin
                    busy[m][c] = 1'b0;
                end else begin
                    code = 2'b00;
                    if (busy[m][c]) begin
                        lat = cyc - t0[m][c];
                        if (gnt[c]) begin
                            busy[m][c] = 1'b0;
                            if (lat >= minl[m]) ep[m][c] = 1'b1;
                            else begin ef[m][c] = 1'b1; code = 2'b01; end
                        end else if (lat == maxl[m]) begin
                            busy[m][c] = 1'b0;
                            ef[m][c] = 1'b1;
                            code = 2'b10;
                        end
                    end
                    if (cStart[c]) begin
                        if (busy[m][c]) eo[m][c] = 1'b1;
                        else if (req[c]) begin busy[m][c] = 1'b1; t0[m][c] = cyc; end
                        else begin ef[m][c] = 1'b1; if (code == 2'b00) code = 2'b11; end
                    end
                    ec[m][2*c +: 2] = code;
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic [3:0] cs, input logic [3:0] r, input logic [3:0] g);
        @(negedge clk);
        en = e; cStart = cs; req = r; gnt = g;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0; cStart = '0; req = '0; gnt = '0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; cStart = '0; req = '0; gnt = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        nvec++; if ({p0, f0, o0, fc0} !== 20'h0) begin nerr++; $display("FAIL reset_out0 got %h want 0", {p0, f0, o0, fc0}); end
        nvec++; if ({pc0, fcnt0, pc1, fcnt1} !== 38'h0) begin nerr++; $display("FAIL reset_cnt got %h want 0", {pc0, fcnt0, pc1, fcnt1}); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_pass();
        do_reset();
        step(1, 4'h1, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h1);
        nvec++; if (p0 !== 4'h1 || f0 !== 4'h0) begin nerr++; $display("FAIL pass0 got p=%h f=%h want p=1 f=0", p0, f0); end
        nvec++; if (p1 !== 4'h1) begin nerr++; $display("FAIL pass1 got %h want 1", p1); end
        step(1, 4'h0, 4'h0, 4'h0);
        nvec++; if (p0 !== 4'h0 || pc0 !== 3'd1 || pc1 !== 16'd1) begin nerr++; $display("FAIL pass_cnt got p=%h c0=%0d c1=%0d want 0/1/1", p0, pc0, pc1); end
    endtask

    task automatic test_fail();
        do_reset();
        step(1, 4'h1, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h1);
        nvec++; if (f0 !== 4'h1 || fc0 !== 8'h01 || f1 !== 4'h1 || fc1 !== 8'h01) begin nerr++; $display("FAIL early got f0=%h c0=%h f1=%h c1=%h want 1/01", f0, fc0, f1, fc1); end
        step(1, 4'h1, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        nvec++; if (f0 !== 4'h1 || fc0 !== 8'h02 || f1 !== 4'h0) begin nerr++; $display("FAIL timeout0 got f0=%h c0=%h f1=%h want 1/02/0", f0, fc0, f1); end
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        nvec++; if (f1 !== 4'h1 || fc1 !== 8'h02) begin nerr++; $display("FAIL timeout1 got f1=%h c1=%h want 1/02", f1, fc1); end
        step(1, 4'h0, 4'h0, 4'h0);
        nvec++; if (fcnt0 !== 3'd2 || fcnt1 !== 16'd2) begin nerr++; $display("FAIL fail_cnt got %0d/%0d want 2/2", fcnt0, fcnt1); end
    endtask

    task automatic test_noreq();
        do_reset();
        step(1, 4'h2, 4'h0, 4'h0);
        nvec++; if (f0 !== 4'h2 || fc0 !== 8'h0C || p0 !== 4'h0) begin nerr++; $display("FAIL no_req got f=%h c=%h p=%h want 2/0c/0", f0, fc0, p0); end
        step(1, 4'h0, 4'h0, 4'h2);
        step(1, 4'h0, 4'h0, 4'h2);
        nvec++; if (p0 !== 4'h0 || f0 !== 4'h0 || fcnt0 !== 3'd1) begin nerr++; $display("FAIL no_req_idle got p=%h f=%h c=%0d want 0/0/1", p0, f0, fcnt0); end
    endtask

    task automatic test_ovl();
        do_reset();
        step(1, 4'h1, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h1, 4'h1, 4'h0);
        nvec++; if (o1 !== 4'h1 || o0 !== 4'h0) begin nerr++; $display("FAIL ovl got o1=%h o0=%h want 1/0", o1, o0); end
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h1, 4'h1, 4'h1);
        nvec++; if (p1 !== 4'h1 || o1 !== 4'h0) begin nerr++; $display("FAIL ovl_pass got p1=%h o1=%h want 1/0", p1, o1); end
        step(1, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h1);
        nvec++; if (p1 !== 4'h1) begin nerr++; $display("FAIL back_to_back got %h want 1", p1); end
    endtask

    task automatic test_saturate();
        do_reset();
        step(1, 4'hF, 4'hF, 4'h0);
        step(1, 4'h0, 4'hF, 4'h0);
        step(1, 4'hF, 4'hF, 4'hF);
        nvec++; if (p0 !== 4'hF) begin nerr++; $display("FAIL all_pass got %h want f", p0); end
        step(1, 4'h0, 4'hF, 4'h0);
        step(1, 4'h0, 4'hF, 4'hF);
        step(1, 4'h0, 4'h0, 4'h0);
        nvec++; if (pc0 !== 3'd7 || pc1 !== 16'd8) begin nerr++; $display("FAIL saturate got %0d/%0d want 7/8", pc0, pc1); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        step(1, 4'h1, 4'h1, 4'h0);
        step(1, 4'h2, 4'h0, 4'h0);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        nvec++; if ({p0, f0, o0, fc0, pc0, fcnt0} !== 26'h0 || {p1, f1, o1, fc1} !== 20'h0) begin nerr++; $display("FAIL async_reset got f0=%h f1=%h fcnt0=%0d want 0", f0, f1, fcnt0); end
        @(negedge clk);
        reset = 1'b1;
        step(1, 4'h0, 4'h1, 4'h1);
        nvec++; if (p0 !== 4'h0 || f0 !== 4'h0 || p1 !== 4'h0) begin nerr++; $display("FAIL reset_abandon got p0=%h f0=%h p1=%h want 0", p0, f0, p1); end
    endtask

    task automatic test_en_abort();
        do_reset();
        step(1, 4'h1, 4'h1, 4'h0);
        step(0, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 4'h1);
        nvec++; if ({p0, f0, p1, f1} !== 16'h0 || pc0 !== 3'd0 || fcnt1 !== 16'd0) begin nerr++; $display("FAIL en_abort got %h pc0=%0d want 0", {p0, f0, p1, f1}, pc0); end
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            step($urandom_range(0, 24) != 0, 4'($urandom & $urandom), 4'(~($urandom & $urandom & $urandom)), 4'($urandom & $urandom));
            nvec++; if (p0 !== ep[0]) begin nerr++; $display("FAIL rnd_pass0 cyc %0d got %h want %h", cyc, p0, ep[0]); end
            nvec++; if (f0 !== ef[0]) begin nerr++; $display("FAIL rnd_fail0 cyc %0d got %h want %h", cyc, f0, ef[0]); end
            nvec++; if (fc0 !== ec[0]) begin nerr++; $display("FAIL rnd_code0 cyc %0d got %h want %h", cyc, fc0, ec[0]); end
            nvec++; if (o0 !== eo[0]) begin nerr++; $display("FAIL rnd_ovl0 cyc %0d got %h want %h", cyc, o0, eo[0]); end
            nvec++; if (pc0 !== epc[0][2:0] || fcnt0 !== efc[0][2:0]) begin nerr++; $display("FAIL rnd_cnt0 cyc %0d got %0d/%0d want %0d/%0d", cyc, pc0, fcnt0, epc[0], efc[0]); end
            nvec++; if (p1 !== ep[1]) begin nerr++; $display("FAIL rnd_pass1 cyc %0d got %h want %h", cyc, p1, ep[1]); end
            nvec++; if (f1 !== ef[1]) begin nerr++; $display("FAIL rnd_fail1 cyc %0d got %h want %h", cyc, f1, ef[1]); end
            nvec++; if (fc1 !== ec[1]) begin nerr++; $display("FAIL rnd_code1 cyc %0d got %h want %h", cyc, fc1, ec[1]); end
            nvec++; if (o1 !== eo[1]) begin nerr++; $display("FAIL rnd_ovl1 cyc %0d got %h want %h", cyc, o1, eo[1]); end
            nvec++; if (pc1 !== epc[1][15:0] || fcnt1 !== efc[1][15:0]) begin nerr++; $display("FAIL rnd_cnt1 cyc %0d got %0d/%0d want %0d/%0d", cyc, pc1, fcnt1, epc[1], efc[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_noreq();
        test_ovl();
        test_saturate();
        test_reset_midwait();
        test_en_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
